// File: rtl/icache_dm_if.sv
// Backing-memory read port of the instruction cache: req/addr out, ack/rdata back.
// The cache drives the master side; the instruction memory sits on the slave side.
interface icache_dm_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with whole-line refill over a req/ack port.
// Optional hit/miss counters are enabled with the ICACHE_PERF_EN macro.
module icache_dm #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic        rd_en,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        stall,
`ifdef ICACHE_PERF_EN
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
`endif
  icache_dm_if.master mem
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TW = 16 - OB - IB;
  localparam logic [OB-1:0] LAST_WORD = OB'(LINE_WORDS - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_t;

  state_t state, state_nxt;

  logic [15:0]   data_arr [0:NUM_LINES*LINE_WORDS-1];
  logic [TW-1:0] tag_arr  [0:NUM_LINES-1];
  logic [NUM_LINES-1:0] valid;

  logic [OB-1:0] word_cnt;
  logic [IB-1:0] fill_index;
  logic [TW-1:0] fill_tag;

  logic [OB-1:0] pc_offset;
  logic [IB-1:0] pc_index;
  logic [TW-1:0] pc_tag;
  logic          hit;
  logic          miss;
  logic          fill_we;
  logic          fill_last;
  logic          mem_req_c;
  logic [15:0]   mem_addr_c;

  assign pc_offset = pc[OB-1:0];
  assign pc_index  = pc[OB+IB-1:OB];
  assign pc_tag    = pc[15:OB+IB];

  assign hit       = valid[pc_index] && (tag_arr[pc_index] == pc_tag);
  assign fill_we   = (state == FILL) && mem.mem_ack && !flush;
  assign fill_last = fill_we && (word_cnt == LAST_WORD);

  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    miss       = 1'b0;
    mem_req_c  = 1'b0;
    mem_addr_c = 16'h0000;
    instr      = data_arr[{pc_index, pc_offset}];
    case (state)
      IDLE: begin
        miss  = rd_en && !hit && !flush;
        stall = miss;
        if (miss) state_nxt = FILL;
      end
      FILL: begin
        // The line base has a zero offset, so base + word_cnt is a plain concatenation.
        mem_req_c  = 1'b1;
        mem_addr_c = {fill_tag, fill_index, word_cnt};
        stall      = !flush;
        if (flush || fill_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rst_n) begin
      stall      = 1'b0;
      mem_req_c  = 1'b0;
      mem_addr_c = 16'h0000;
      instr      = 16'h0000;
    end
  end

  assign mem.mem_req  = mem_req_c;
  assign mem.mem_addr = mem_addr_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid    <= '0;
      word_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (flush) begin
        valid <= '0;
      end else if (fill_last) begin
        valid[fill_index] <= 1'b1;
      end
      if (miss) begin
        word_cnt <= '0;
      end else if (fill_we) begin
        word_cnt <= word_cnt + 1'b1;
      end
    end
  end

  // Storage and the latched fill address are never cleared; valid bits alone gate hits.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (miss) begin
        fill_index <= pc_index;
        fill_tag   <= pc_tag;
      end
      if (fill_we) begin
        data_arr[{fill_index, word_cnt}] <= mem.mem_rdata;
      end
      if (fill_last) begin
        tag_arr[fill_index] <= fill_tag;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic hit_evt;

  assign hit_evt = (state == IDLE) && rd_en && hit && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      hit_cnt  <= 16'h0000;
      miss_cnt <= 16'h0000;
    end else begin
      if (hit_evt && (hit_cnt != 16'hFFFF)) hit_cnt <= hit_cnt + 16'd1;
      if (miss && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/icache_dm.md
# icache_dm

Direct-mapped, read-only instruction cache between the processor's IF stage and a multi-cycle backing instruction memory. On a hit it returns the 16-bit instruction for `pc` in the same cycle. On a miss it asserts `stall` and fills the whole line word-by-word over a req/ack handshake. While `stall` is high, the hazard logic holds the PC and the IF/ID register; `stall` drops when the line has been installed.

## Interface
Parameters:
- `LINE_WORDS`, default 4, words per line; power of two, ≥2.
- `NUM_LINES`, default 8, number of lines; power of two, ≥2.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pc` in 16: word address of the instruction to fetch.
- `rd_en` in 1: fetch request for this cycle.
- `flush` in 1: invalidate all lines.
- `instr` out 16: instruction word, valid when `rd_en & ~stall`.
- `stall` out 1: miss in progress; freeze PC and IF/ID.
- `mem_req` out 1: backing-memory read request.
- `mem_addr` out 16: word address for `mem_req`.
- `mem_ack` in 1: backing memory has returned `mem_rdata` this cycle.
- `mem_rdata` in 16: backing memory read data.

## Operation
Address split:
- offset = `pc[OB-1:0]`, where OB = log2(LINE_WORDS).
- index = `pc[OB+IB-1:OB]`, where IB = log2(NUM_LINES).
- tag = `pc[15:OB+IB]`.

Storage:
- data array of NUM_LINES×LINE_WORDS×16 bits.
- tag array of NUM_LINES×(16−OB−IB) bits.
- one valid bit per line.

Hit:
- hit = `valid[index] & tag_arr[index]==tag`.
- `instr` = data[index][offset], combinational from `pc`.

FSM states: IDLE and FILL.
- IDLE:
  - `stall` = `rd_en & ~hit & ~flush`.
  - When `stall` is high, latch fill_base = {tag, index, OB'b0} and set word_cnt = 0.
  - Go to FILL on the next edge.
- FILL:
  - `mem_req` = 1 and `mem_addr` = fill_base + word_cnt.
  - `stall` = 1 regardless of `pc`.
  - On each edge with `mem_ack` = 1: write `mem_rdata` to data[fill_index][word_cnt], then increment word_cnt.
  - On the ack where word_cnt = LINE_WORDS−1: write the tag, set valid, return to IDLE.
  - The next cycle re-evaluates `pc`; it hits if `pc` is unchanged.
- `mem_addr` stays stable while `mem_req` is high and no ack has arrived. `mem_ack` may arrive in the same cycle `mem_req` first rises.
- `mem_ack` while not in FILL is ignored.
- `rd_en` = 0 in IDLE: no miss, `stall` = 0, `instr` is don't-care (drives the array word).

Flush:
- `flush` clears all valid bits on the next edge.
- In FILL, `flush` aborts the fill: next state is IDLE, `mem_req` drops, and the partial line stays invalid. The backing memory must accept a withdrawn request.
- An ack coincident with `flush` is discarded.
- `flush` forces `stall` = 0 in that cycle. The fetch is retried the next cycle and misses.

Reset (edge with `rst_n` = 0):
- State = IDLE, all valid bits = 0, word_cnt = 0.
- `mem_req` = 0, `mem_addr` = 0, `stall` = 0, `instr` = 0 (forced while in reset).
- Reset mid-fill abandons the fill with no array write.
- Data and tag arrays are not reset.

## Timing
- Hit latency: 0 cycles; `instr` is combinational in the same cycle as `pc`.
- Miss penalty: 1 (IDLE→FILL) + Σ(ack wait per word) cycles. With single-cycle ack the penalty is LINE_WORDS+1 cycles of `stall`, and the instruction is returned in the following cycle.
- `stall` is combinational in IDLE and registered-state-driven in FILL.
- Array writes, tag/valid updates and state updates occur on the rising edge of `clk` only.

## Configuration
- `ICACHE_PERF_EN` defined:
  - Adds outputs `hit_cnt` (out 16) and `miss_cnt` (out 16).
  - `hit_cnt` increments on each IDLE cycle with `rd_en & hit & ~flush`.
  - `miss_cnt` increments on each IDLE→FILL transition.
  - Both counters saturate at 16'hFFFF and are cleared by reset and by `flush`.
- `ICACHE_PERF_EN` undefined: the ports and counters are absent. Functional behaviour is identical.

## Test plan
- Cold miss:
  - Stimulus: after reset, `pc`=16'h0005 and `rd_en`=1; memory acks every cycle and returns data = 16'hA000+addr.
  - Required: `stall` high for 5 cycles; `mem_addr` sequence 4,5,6,7; then `instr`=16'hA005 with `stall`=0.
- Same-line hits:
  - Stimulus: `pc`=4,5,6,7 consecutively after the fill above.
  - Required: `stall`=0 in every cycle; `instr`=A004..A007; no `mem_req`.
- Conflict eviction (defaults):
  - Stimulus: `pc`=16'h0024, which has the same index 1 as line 4–7 but a different tag.
  - Required: miss and fill of 16'h0024–16'h0027; a later `pc`=5 misses again.
- Delayed ack:
  - Stimulus: memory acks 3 cycles after each request.
  - Required: `mem_addr` stable across the waits; `stall` lasts 1+4×3 cycles; correct data is installed.
- Flush mid-fill:
  - Stimulus: assert `flush` after the 2nd ack of a fill.
  - Required: `mem_req`=0 next cycle; state IDLE; retry of the same `pc` misses and refetches the full line from the line base.
- Reset mid-fill and counters:
  - Stimulus: `rst_n`=0 during FILL; with `ICACHE_PERF_EN`, run 1 miss followed by 3 hits.
  - Required: `mem_req`=0 and `stall`=0 after the reset edge, and the previously valid line now misses; `miss_cnt`=1 and `hit_cnt`=3 (the retry cycle after the fill counts as a hit).
